// File: rtl/dsa_pkg.sv
// Shared types and constants for the scaler write path: drain FSM states and
// byte-lane geometry of the 32-bit memory word.
package dsa_pkg;

    localparam int unsigned LANES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = LANES_PER_WORD * BYTE_W;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    // Place a byte in its little-endian lane, zeros elsewhere.
    function automatic logic [WORD_W-1:0] lane_place(input logic [1:0]        lane,
                                                     input logic [BYTE_W-1:0] b);
        return {{(WORD_W - BYTE_W){1'b0}}, b} << {lane, 3'b000};
    endfunction

    function automatic logic [LANES_PER_WORD-1:0] lane_onehot(input logic [1:0] lane);
        return {{(LANES_PER_WORD - 1){1'b0}}, 1'b1} << lane;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. A push into a full FIFO is accepted only when a
// pop happens on the same edge; otherwise it is silently discarded.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      count_q;
    logic             do_push, do_pop;

    always_comb begin
        empty_o = (count_q == '0);
        full_o  = (count_q == (PW + 1)'(DEPTH));
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        count_o = count_q;
        // Head is forced to zero when empty so nothing stale is ever presented.
        rdata_o = empty_o ? '0 : mem_q[rptr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/pixel_word_packer.sv
// Packs the scaler's byte-wide raster write stream into 32-bit little-endian
// words with byte enables, buffers them and drains the partial word on flush.
module pixel_word_packer
    import dsa_pkg::*;
#(
    parameter int unsigned AW         = 19,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_px_we,
    input  logic [AW-1:0] i_px_addr,
    input  logic [7:0]    i_px_data,
    input  logic          i_flush,
    output logic          o_mem_valid,
    input  logic          i_mem_ready,
    output logic [AW-3:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    output logic [3:0]    o_mem_be,
    output logic          o_busy,
    output logic          o_flush_done,
    output logic          o_overflow,
    output logic [31:0]   o_word_count
);

    localparam int unsigned WAW     = AW - 2;
    localparam int unsigned ENTRY_W = WAW + WORD_W + LANES_PER_WORD;

    state_e                    state_q, state_d;
    logic                      pk_valid_q, pk_valid_d;
    logic [WAW-1:0]            pk_waddr_q, pk_waddr_d;
    logic [WORD_W-1:0]         pk_data_q, pk_data_d;
    logic [LANES_PER_WORD-1:0] pk_be_q, pk_be_d;
    logic                      overflow_q, overflow_d;
    logic [31:0]               word_count_q, word_count_d;

    logic [WAW-1:0]            px_waddr;
    logic [1:0]                px_lane;
    logic                      same_word;
    logic                      pix_push, drain_push, push;
    logic [ENTRY_W-1:0]        push_entry, head_entry;
    logic                      fifo_full, fifo_empty, pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // Pack register update and push selection.
    always_comb begin
        px_waddr   = i_px_addr[AW-1:2];
        px_lane    = i_px_addr[1:0];
        same_word  = pk_valid_q && (pk_waddr_q == px_waddr);
        pk_valid_d = pk_valid_q;
        pk_waddr_d = pk_waddr_q;
        pk_data_d  = pk_data_q;
        pk_be_d    = pk_be_q;
        pix_push   = 1'b0;
        drain_push = 1'b0;
        push_entry = {pk_waddr_q, pk_data_q, pk_be_q};

        if (i_px_we) begin
            if (same_word) begin
                pk_data_d = (pk_data_q & ~lane_place(px_lane, 8'hFF))
                          | lane_place(px_lane, i_px_data);
                pk_be_d   = pk_be_q | lane_onehot(px_lane);
            end else begin
                // A pixel in a new word evicts the old pack (if any).
                pix_push   = pk_valid_q;
                pk_valid_d = 1'b1;
                pk_waddr_d = px_waddr;
                pk_data_d  = lane_place(px_lane, i_px_data);
                pk_be_d    = lane_onehot(px_lane);
            end
            if (pk_be_d == '1) begin
                pix_push   = 1'b1;
                push_entry = {pk_waddr_d, pk_data_d, pk_be_d};
                pk_valid_d = 1'b0;
            end
        end

        // The drain carries any same-cycle merge, never a freshly loaded word.
        if (state_q == S_DRAIN && pk_valid_q && !pix_push) begin
            drain_push = 1'b1;
            push_entry = {pk_waddr_d, pk_data_d, pk_be_d};
            pk_valid_d = 1'b0;
        end

        push = pix_push || drain_push;

        if (i_clear) begin
            pk_valid_d = 1'b0;
            pk_waddr_d = '0;
            pk_data_d  = '0;
            pk_be_d    = '0;
        end
    end

    // Flush FSM, overflow and word counter.
    always_comb begin
        state_d      = state_q;
        overflow_d   = overflow_q;
        word_count_d = word_count_q;
        o_flush_done = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (i_flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = pix_push ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (fifo_empty) begin
                    o_flush_done = 1'b1;
                    state_d      = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase

        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            word_count_d = word_count_q + 32'd1;
        end

        if (i_clear) begin
            state_d      = S_RUN;
            overflow_d   = 1'b0;
            word_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RUN;
            pk_valid_q   <= 1'b0;
            pk_waddr_q   <= '0;
            pk_data_q    <= '0;
            pk_be_q      <= '0;
            overflow_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pk_valid_q   <= pk_valid_d;
            pk_waddr_q   <= pk_waddr_d;
            pk_data_q    <= pk_data_d;
            pk_be_q      <= pk_be_d;
            overflow_q   <= overflow_d;
            word_count_q <= word_count_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (i_clear),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        o_mem_valid  = !fifo_empty;
        pop          = o_mem_valid && i_mem_ready;
        o_mem_addr   = head_entry[ENTRY_W-1 -: WAW];
        o_mem_wdata  = head_entry[WORD_W + LANES_PER_WORD - 1 : LANES_PER_WORD];
        o_mem_be     = head_entry[LANES_PER_WORD-1:0];
        o_busy       = pk_valid_q || (fifo_count != '0) || (state_q != S_RUN);
        o_overflow   = overflow_q;
        o_word_count = word_count_q;
    end

endmodule

// File: doc/pixel_word_packer.md
# pixel_word_packer

Downstream write stage for the bilinear scaler core. It takes the core's byte-wide destination write stream (`out_waddr`/`out_wdata`/`out_we`) and packs raster-order pixels into 32-bit little-endian words with byte enables. Packed words are buffered in a small FIFO and presented on a valid/ready word-memory port. The block also provides a flush handshake, driven by the core's `done`, so the final partial word reaches memory before software reads the counters.

## Interface
- `AW`, 19: pixel (byte) address width, matching the core.
- `FIFO_DEPTH`, 4: word FIFO entries; power of two, ≥2.

- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_clear`  in  1  synchronous clear: discards the pack register and the FIFO, zeroes counters and overflow, returns to S_RUN.
- `i_px_we`  in  1  pixel write strobe (core `out_we`).
- `i_px_addr`  in  AW  pixel byte address (core `out_waddr`).
- `i_px_data`  in  8  pixel value (core `out_wdata`).
- `i_flush`  in  1  single-cycle flush request (core `done`).
- `o_mem_valid`  out  1  head FIFO word valid.
- `i_mem_ready`  in  1  memory accepts the word when valid & ready.
- `o_mem_addr`  out  AW-2  word address = pixel address[AW-1:2].
- `o_mem_wdata`  out  32  packed word; lane k occupies bits [8k+7:8k].
- `o_mem_be`  out  4  byte enables.
- `o_busy`  out  1  pack register valid, FIFO non-empty, or state ≠ S_RUN.
- `o_flush_done`  out  1  one-cycle pulse when a flush completes.
- `o_overflow`  out  1  sticky: a word was dropped.
- `o_word_count`  out  32  words accepted by memory since reset or clear.

Reset values: every output is 0, the FIFO is empty, the pack register is invalid, and the state is S_RUN.

## Operation
- Pack register holds `pk_valid`, `pk_waddr` (AW-2 bits), `pk_data` (32 bits), `pk_be` (4 bits). Lane = `i_px_addr[1:0]`.
- Pixel write, pack register invalid: load waddr, place the byte in its lane, set `pk_be` one-hot.
- Pixel write, same word: merge the byte. A lane already set is overwritten, with no error.
- Pixel write, different word: push the old pack to the FIFO, then load the new pixel as above.
- Merge that makes `pk_be == 4'hF`: push the merged word on the same edge and clear `pk_valid`.
- At most one FIFO push per cycle. A pixel-caused push has priority over a flush-caused push.
- Push when FIFO is full with no pop in the same cycle: the pushed word is dropped and `o_overflow` is set. Push and pop together when full is legal.
- FIFO is show-ahead. `o_mem_*` reflect the head entry. Pop on `o_mem_valid & i_mem_ready`, which also increments `o_word_count` (wraps at 2^32).
- FSM `S_RUN`/`S_DRAIN`/`S_WAIT`:
  - S_RUN: `i_flush` → S_DRAIN.
  - S_DRAIN: if `pk_valid` and no pixel-caused push this cycle, push the pack and go to S_WAIT. If a pixel-caused push occurs, stay in S_DRAIN. If `pk_valid` = 0, go to S_WAIT.
  - S_WAIT: when the FIFO is empty and no pop is pending, pulse `o_flush_done` and go to S_RUN.
- `i_flush` in S_DRAIN or S_WAIT is ignored, and no second pulse is produced.
- Pixel writes are accepted in every state. Pixels arriving after the S_DRAIN push stay in the pack register and are not covered by that flush.
- `i_px_we` together with `i_flush` in S_RUN: the pixel is merged first, and the drain pushes the result.
- `i_clear` together with any other event: clear wins.
- `rst` mid-operation: all buffered data is lost and no flush-done pulse is produced.

## Timing
- A word-completing pixel at edge N gives `o_mem_valid` = 1 in the cycle after edge N. The same word leaves on the first edge ≥ N+1 with `i_mem_ready` = 1.
- Throughput: one push and one pop per cycle. The core produces ≤1 pixel per 8 cycles, so `FIFO_DEPTH` = 4 absorbs up to 128 stall cycles after a full word.
- Flush with FIFO empty and `i_mem_ready` = 1: `i_flush` at edge F, drain push at F+1, pop at F+2, `o_flush_done` high after F+2 for one cycle.
- `o_busy` is registered from current state and contents; there is no combinational path from inputs to outputs except through FIFO head selection.

## Structure
- Shared package `dsa_pkg`: FSM state enum (`S_RUN`, `S_DRAIN`, `S_WAIT`), `LANES_PER_WORD` = 4, `BYTE_W` = 8.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): show-ahead FIFO with full, empty and count outputs. Instantiated with WIDTH = (AW-2) + 32 + 4.

## Test plan
- Addresses 0..3, data 0x11/0x22/0x33/0x44, ready = 1 → one word: addr 0, wdata 0x44332211, be 0xF; word_count = 1; pack register empty.
- Address 5 = 0xAA, address 6 = 0xBB, then address 12 = 0xCC → word: addr 1, wdata 0x00BBAA00, be 0x6; pack register holds addr 3, be 0x1.
- Address 8 = 0x5A, then `i_flush` → word: addr 2, wdata 0x0000005A, be 0x1; `o_flush_done` pulses once, 3 cycles after the flush edge.
- ready = 0, 5 full words (addresses 0..19) → 4 buffered, 5th dropped, `o_overflow` = 1; ready = 1 → words 0..3 emitted in order, word_count = 4.
- Address 3 write together with `i_flush`, after addresses 0..2 → exactly one word, be 0xF; no extra empty word; one `o_flush_done`.
- `rst` asserted while the FIFO holds 2 words → all outputs 0 immediately; after release, the next pixel starts a fresh pack and no stale word appears.
